// File: rtl/sa_matmul_nxn_if.sv
// Operand/result stream bundle for the NxN systolic multiplier.
// master = operand fetch / result writeback side, slave = the array.
interface sa_matmul_nxn_if #(
  parameter int DATA_WIDTH = 4,
  parameter int N          = 2,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(N)
);
  logic                       in_valid;
  logic                       in_ready;
  logic [N*DATA_WIDTH-1:0]    a_col;
  logic [N*DATA_WIDTH-1:0]    b_row;
  logic                       out_valid;
  logic                       out_ready;
  logic [N*N*ACC_WIDTH-1:0]   c_flat;
  logic                       busy;

  modport master (
    output in_valid, a_col, b_row, out_ready,
    input  in_ready, out_valid, c_flat, busy
  );

  modport slave (
    input  in_valid, a_col, b_row, out_ready,
    output in_ready, out_valid, c_flat, busy
  );
endinterface

// File: rtl/sa_matmul_nxn.sv
// Output-stationary NxN systolic matrix multiplier, C = A x B.
// Beat k carries column k of A and row k of B; skewing is done here,
// so the producer streams unskewed beats.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_LOAD  | accepting operand beats 0..N-1 (in_ready=1)
//   S_FLUSH | last beat in; wavefront draining through array (2N cycles)
//   S_DONE  | C valid and held; waits for out_ready, then clears array
module sa_matmul_nxn #(
  parameter int DATA_WIDTH = 4,
  parameter int N          = 2,
  parameter int SIGNED     = 0,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  sa_matmul_nxn_if.slave mm
);
  localparam int DW = DATA_WIDTH;
  localparam int PW = 2*DATA_WIDTH;
  localparam int CW = $clog2(N);
  localparam int FW = $clog2(2*N);
  localparam logic [CW-1:0] LAST_BEAT  = CW'(N-1);
  // Loaded on the last-beat edge; terminal count lands on edge t_L+2N.
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(2*N-1);

  typedef enum logic [1:0] {S_LOAD, S_FLUSH, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_beat_cnt, w_beat_cnt_nxt;
  logic [FW-1:0] r_flush_cnt, w_flush_cnt_nxt;
  logic          w_in_ready, w_out_valid;
  logic          w_accept, w_clear;

  // State register, beat counter and flush down-counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_LOAD;
      r_beat_cnt  <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  // Next-state, counter updates and handshake outputs
  always_comb begin
    w_state_nxt     = r_state;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_flush_cnt_nxt = r_flush_cnt;
    w_in_ready      = 1'b0;
    w_out_valid     = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        w_in_ready = 1'b1;
        if (mm.in_valid) begin
          if (r_beat_cnt == LAST_BEAT) begin
            w_beat_cnt_nxt  = '0;
            w_flush_cnt_nxt = FLUSH_LOAD;
            w_state_nxt     = S_FLUSH;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (r_flush_cnt == '0) w_state_nxt = S_DONE;
        else                   w_flush_cnt_nxt = r_flush_cnt - 1'b1;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (mm.out_ready) w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  assign w_accept     = w_in_ready & mm.in_valid;
  assign w_clear      = w_out_valid & mm.out_ready;
  assign mm.in_ready  = w_in_ready;
  assign mm.out_valid = w_out_valid;
  assign mm.busy      = (r_state != S_LOAD) || (r_beat_cnt != '0);

  // Operand seen by PE(i,j) during the current cycle, with its valid tag.
  logic [DW-1:0]        w_a_d [N][N];
  logic                 w_a_v [N][N];
  logic [DW-1:0]        w_b_d [N][N];
  logic                 w_b_v [N][N];
  logic [ACC_WIDTH-1:0] w_acc [N][N];
  logic [N*N*ACC_WIDTH-1:0] w_c_flat;

  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    logic [DW-1:0] r_a_sk_d [0:gi];
    logic          r_a_sk_v [0:gi];
    logic [DW-1:0] r_b_sk_d [0:gi];
    logic          r_b_sk_v [0:gi];

    // Row gi of A / column gi of B get gi extra cycles of delay; idle cycles shift in untagged zeros
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s <= gi; s++) begin
          r_a_sk_d[s] <= '0;
          r_a_sk_v[s] <= 1'b0;
          r_b_sk_d[s] <= '0;
          r_b_sk_v[s] <= 1'b0;
        end
      end else begin
        r_a_sk_d[0] <= w_accept ? mm.a_col[gi*DW +: DW] : '0;
        r_a_sk_v[0] <= w_accept;
        r_b_sk_d[0] <= w_accept ? mm.b_row[gi*DW +: DW] : '0;
        r_b_sk_v[0] <= w_accept;
        for (int s = 1; s <= gi; s++) begin
          r_a_sk_d[s] <= r_a_sk_d[s-1];
          r_a_sk_v[s] <= r_a_sk_v[s-1];
          r_b_sk_d[s] <= r_b_sk_d[s-1];
          r_b_sk_v[s] <= r_b_sk_v[s-1];
        end
      end
    end

    assign w_a_d[gi][0] = r_a_sk_d[gi];
    assign w_a_v[gi][0] = r_a_sk_v[gi];
    assign w_b_d[0][gi] = r_b_sk_d[gi];
    assign w_b_v[0][gi] = r_b_sk_v[gi];
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [ACC_WIDTH-1:0] r_acc;
      logic [PW-1:0]        w_prod;
      logic [ACC_WIDTH-1:0] w_prod_ext;
      logic                 w_fire;

      assign w_fire = w_a_v[gi][gj] & w_b_v[gi][gj];

      if (SIGNED != 0) begin : g_s
        logic signed [PW-1:0] w_sa, w_sb;
        assign w_sa       = {{DW{w_a_d[gi][gj][DW-1]}}, w_a_d[gi][gj]};
        assign w_sb       = {{DW{w_b_d[gi][gj][DW-1]}}, w_b_d[gi][gj]};
        assign w_prod     = w_sa * w_sb;
        assign w_prod_ext = {{(ACC_WIDTH-PW){w_prod[PW-1]}}, w_prod};
      end else begin : g_u
        assign w_prod     = {{DW{1'b0}}, w_a_d[gi][gj]} * {{DW{1'b0}}, w_b_d[gi][gj]};
        assign w_prod_ext = {{(ACC_WIDTH-PW){1'b0}}, w_prod};
      end

      // Accumulate on tagged cycles; a taken result clears the array for the next matrix
      always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_acc <= '0;
        else if (w_clear) r_acc <= '0;
        else if (w_fire)  r_acc <= r_acc + w_prod_ext;
      end
      assign w_acc[gi][gj] = r_acc;

      if (gj < N-1) begin : g_a_pipe
        logic [DW-1:0] r_a_d;
        logic          r_a_v;
        // Pass A one column to the right
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_a_d <= '0;
            r_a_v <= 1'b0;
          end else begin
            r_a_d <= w_a_d[gi][gj];
            r_a_v <= w_a_v[gi][gj];
          end
        end
        assign w_a_d[gi][gj+1] = r_a_d;
        assign w_a_v[gi][gj+1] = r_a_v;
      end

      if (gi < N-1) begin : g_b_pipe
        logic [DW-1:0] r_b_d;
        logic          r_b_v;
        // Pass B one row down
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_b_d <= '0;
            r_b_v <= 1'b0;
          end else begin
            r_b_d <= w_b_d[gi][gj];
            r_b_v <= w_b_v[gi][gj];
          end
        end
        assign w_b_d[gi+1][gj] = r_b_d;
        assign w_b_v[gi+1][gj] = r_b_v;
      end
    end
  end

  // Flatten accumulators row-major onto the result bus
  always_comb begin
    w_c_flat = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        w_c_flat[(i*N+j)*ACC_WIDTH +: ACC_WIDTH] = w_acc[i][j];
      end
    end
  end

  assign mm.c_flat = w_c_flat;
endmodule

// File: tb/tb_sa_matmul_nxn.sv
// Bench for sa_matmul_nxn: three instances (N=2 unsigned, N=2 signed,
// N=4 unsigned) share one clock/reset. A driver pushes expected results
// into per-instance queues; a monitor pops and compares on out_valid rise.
module tb_sa_matmul_nxn;
  typedef int mat_t [4][4];
  typedef struct {
    logic [159:0] c;
    int           t_exp;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic         in_valid    [3];
  logic [15:0]  a_col       [3];
  logic [15:0]  b_row       [3];
  logic         out_ready   [3];
  logic         in_ready_w  [3];
  logic         out_valid_w [3];
  logic         busy_w      [3];
  logic [159:0] c_w         [3];

  sa_matmul_nxn_if #(.DATA_WIDTH(4), .N(2), .ACC_WIDTH(9))  if0 ();
  sa_matmul_nxn_if #(.DATA_WIDTH(4), .N(2), .ACC_WIDTH(9))  if1 ();
  sa_matmul_nxn_if #(.DATA_WIDTH(4), .N(4), .ACC_WIDTH(10)) if2 ();

  assign if0.in_valid  = in_valid[0];
  assign if0.a_col     = a_col[0][7:0];
  assign if0.b_row     = b_row[0][7:0];
  assign if0.out_ready = out_ready[0];
  assign if1.in_valid  = in_valid[1];
  assign if1.a_col     = a_col[1][7:0];
  assign if1.b_row     = b_row[1][7:0];
  assign if1.out_ready = out_ready[1];
  assign if2.in_valid  = in_valid[2];
  assign if2.a_col     = a_col[2];
  assign if2.b_row     = b_row[2];
  assign if2.out_ready = out_ready[2];

  assign in_ready_w[0]  = if0.in_ready;
  assign in_ready_w[1]  = if1.in_ready;
  assign in_ready_w[2]  = if2.in_ready;
  assign out_valid_w[0] = if0.out_valid;
  assign out_valid_w[1] = if1.out_valid;
  assign out_valid_w[2] = if2.out_valid;
  assign busy_w[0]      = if0.busy;
  assign busy_w[1]      = if1.busy;
  assign busy_w[2]      = if2.busy;
  assign c_w[0]         = {124'b0, if0.c_flat};
  assign c_w[1]         = {124'b0, if1.c_flat};
  assign c_w[2]         = if2.c_flat;

  sa_matmul_nxn #(.DATA_WIDTH(4), .N(2), .SIGNED(0), .ACC_WIDTH(9))
    u_dut0 (.clk(clk), .rst(rst), .mm(if0));
  sa_matmul_nxn #(.DATA_WIDTH(4), .N(2), .SIGNED(1), .ACC_WIDTH(9))
    u_dut1 (.clk(clk), .rst(rst), .mm(if1));
  sa_matmul_nxn #(.DATA_WIDTH(4), .N(4), .SIGNED(0), .ACC_WIDTH(10))
    u_dut2 (.clk(clk), .rst(rst), .mm(if2));

  sb_t q0[$];
  sb_t q1[$];
  sb_t q2[$];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer matrix product, truncated to the result width.
  function automatic longint sval(input int v, input bit sgn);
    int u;
    u = v & 15;
    if (sgn && u >= 8) return longint'(u - 16);
    return longint'(u);
  endfunction

  function automatic logic [159:0] model(input mat_t a, input mat_t b, input int n,
                                         input bit sgn, input int accw);
    logic [159:0] r;
    longint       s;
    r = '0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++) s += sval(a[i][k], sgn) * sval(b[k][j], sgn);
        for (int bt = 0; bt < accw; bt++) r[(i*n+j)*accw+bt] = s[bt];
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] col_of(input mat_t a, input int kk, input int n);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i*4 +: 4] = 4'(a[i][kk]);
    return v;
  endfunction

  function automatic logic [15:0] row_of(input mat_t b, input int kk, input int n);
    logic [15:0] v;
    v = '0;
    for (int j = 0; j < n; j++) v[j*4 +: 4] = 4'(b[kk][j]);
    return v;
  endfunction

  task automatic rand_mat(input int n, output mat_t m);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        m[i][j] = (i < n && j < n) ? int'($urandom_range(0, 15)) : 0;
  endtask

  task automatic ident_mat(output mat_t m);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        m[i][j] = (i == j) ? 1 : 0;
  endtask

  // Present one beat until accepted; returns edge index of acceptance.
  task automatic issue_beat(input int k, input logic [15:0] ac, input logic [15:0] br,
                            output int t_acc);
    logic rdy;
    int   tries;
    bit   done;
    in_valid[k] = 1'b1;
    a_col[k]    = ac;
    b_row[k]    = br;
    done  = 1'b0;
    tries = 0;
    t_acc = -1;
    while (!done) begin
      @(negedge clk);
      rdy = in_ready_w[k];
      @(posedge clk);
      #1;
      if (rdy) begin
        done  = 1'b1;
        t_acc = cyc;
      end else begin
        tries++;
        if (tries >= 60) begin
          checks++;
          errors++;
          $display("FAIL beat_accept_timeout dut%0d: in_ready stayed 0, required 1 within 60 cycles", k);
          done = 1'b1;
        end
      end
    end
    in_valid[k] = 1'b0;
  endtask

  task automatic send_matrix(input int k, input int n, input mat_t a, input mat_t b,
                             input int gap, input bit sgn, input int accw, output int t_last);
    sb_t e;
    t_last = -1;
    for (int kk = 0; kk < n; kk++) begin
      if (kk > 0) repeat (gap) begin
        @(posedge clk);
        #1;
      end
      issue_beat(k, col_of(a, kk, n), row_of(b, kk, n), t_last);
    end
    e.c     = model(a, b, n, sgn, accw);
    e.t_exp = t_last + 2*n;
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // From the last-beat edge through DONE in_ready must stay low, then return.
  task automatic flush_watch(input int k, input int n);
    for (int c = 0; c <= 2*n; c++) begin
      chk($sformatf("flush_in_ready_dut%0d_c%0d", k, c), in_ready_w[k], 1'b0);
      @(posedge clk);
      #1;
    end
    chk($sformatf("post_done_in_ready_dut%0d", k), in_ready_w[k], 1'b1);
    chk($sformatf("post_done_out_valid_dut%0d", k), out_valid_w[k], 1'b0);
  endtask

  task automatic check_result(input int k);
    sb_t e;
    bit  have;
    have = 1'b1;
    case (k)
      0:       if (q0.size() == 0) have = 1'b0; else e = q0.pop_front();
      1:       if (q1.size() == 0) have = 1'b0; else e = q1.pop_front();
      default: if (q2.size() == 0) have = 1'b0; else e = q2.pop_front();
    endcase
    chk($sformatf("result_expected_dut%0d", k), have, 1'b1);
    if (have) begin
      chk($sformatf("result_c_dut%0d", k), c_w[k], e.c);
      chk($sformatf("result_edge_dut%0d", k), cyc, e.t_exp);
    end
  endtask

  // Monitor: compare on each rising out_valid, sampled mid-cycle
  logic prev_v [3];
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        prev_v[k] = 1'b0;
      end else begin
        if (out_valid_w[k] && !prev_v[k]) check_result(k);
        prev_v[k] = out_valid_w[k];
      end
    end
  end

  initial begin
    mat_t a, b, ra, rb;
    int   t_l;
    int   n;
    int   w;
    logic [159:0] bp_exp;

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      a_col[k]     = '0;
      b_row[k]     = '0;
      out_ready[k] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_in_ready_dut%0d", k), in_ready_w[k], 1'b1);
      chk($sformatf("rst_out_valid_dut%0d", k), out_valid_w[k], 1'b0);
      chk($sformatf("rst_busy_dut%0d", k), busy_w[k], 1'b0);
      chk($sformatf("rst_c_dut%0d", k), c_w[k], '0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back N=2 unsigned
    a = '{'{5, 1, 0, 0}, '{13, 6, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
    b = '{'{6, 10, 0, 0}, '{14, 2, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
    send_matrix(0, 2, a, b, 0, 1'b0, 9, t_l);
    chk("flush_busy", busy_w[0], 1'b1);
    flush_watch(0, 2);

    // Same operands with a 3-cycle gap between beats
    send_matrix(0, 2, a, b, 3, 1'b0, 9, t_l);
    flush_watch(0, 2);

    // Maximum unsigned operands
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
      a[i][j] = (i < 2 && j < 2) ? 15 : 0;
      b[i][j] = a[i][j];
    end
    send_matrix(0, 2, a, b, 0, 1'b0, 9, t_l);

    // Signed corners: -8*-8 and -8*7
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
      a[i][j] = (i < 2 && j < 2) ? 8 : 0;
      b[i][j] = a[i][j];
    end
    send_matrix(1, 2, a, b, 0, 1'b1, 9, t_l);
    for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) b[i][j] = 7;
    send_matrix(1, 2, a, b, 1, 1'b1, 9, t_l);

    // Backpressure: hold result 5 cycles while offering ignored beats
    out_ready[0] = 1'b0;
    rand_mat(2, ra);
    rand_mat(2, rb);
    bp_exp = model(ra, rb, 2, 1'b0, 9);
    send_matrix(0, 2, ra, rb, 0, 1'b0, 9, t_l);
    w = 0;
    while (!out_valid_w[0] && w < 40) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("bp_out_valid_seen", out_valid_w[0], 1'b1);
    repeat (5) begin
      in_valid[0] = 1'b1;
      a_col[0]    = 16'($urandom);
      b_row[0]    = 16'($urandom);
      chk("bp_hold_c", c_w[0], bp_exp);
      chk("bp_hold_in_ready", in_ready_w[0], 1'b0);
      chk("bp_hold_out_valid", out_valid_w[0], 1'b1);
      @(posedge clk);
      #1;
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", out_valid_w[0], 1'b0);
    chk("bp_release_cleared_c", c_w[0], '0);
    chk("bp_release_busy", busy_w[0], 1'b0);
    ident_mat(a);
    b = '{'{3, 4, 0, 0}, '{5, 6, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
    send_matrix(0, 2, a, b, 0, 1'b0, 9, t_l);
    repeat (12) @(posedge clk);
    #1;

    // Reset after beat 0 discards the partial matrix
    rand_mat(2, ra);
    rand_mat(2, rb);
    ra[0][0] = int'($urandom_range(1, 15));
    rb[0][0] = int'($urandom_range(1, 15));
    issue_beat(0, col_of(ra, 0, 2), row_of(rb, 0, 2), t_l);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("mid_busy", busy_w[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid_w[0], 1'b0);
    chk("mid_rst_c", c_w[0], '0);
    chk("mid_rst_in_ready", in_ready_w[0], 1'b1);
    chk("mid_rst_busy", busy_w[0], 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_matrix(0, 2, ra, rb, 0, 1'b0, 9, t_l);

    // N=4 identity x B returns B
    ident_mat(a);
    rand_mat(4, rb);
    send_matrix(2, 4, a, rb, 0, 1'b0, 10, t_l);

    // Randomized operands and gaps across all three instances
    for (int r = 0; r < 12; r++) begin
      int k;
      k = r % 3;
      n = (k == 2) ? 4 : 2;
      rand_mat(n, ra);
      rand_mat(n, rb);
      send_matrix(k, n, ra, rb, int'($urandom_range(0, 2)), (k == 1), (k == 2) ? 10 : 9, t_l);
    end

    w = 0;
    while ((q0.size() != 0 || q1.size() != 0 || q2.size() != 0) && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    chk("drain_q2", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
